// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, parity-type constants, default width
// and prescale helpers used by both TX and RX blocks.
package uart_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned PRESCALE_W         = 6;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Last tick index of a bit; a prescale of 0 behaves like 1.
  function automatic logic [PRESCALE_W-1:0] tick_limit(input logic [PRESCALE_W-1:0] prescale);
    return (prescale == '0) ? '0 : prescale - PRESCALE_W'(1);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Parallel-side request bundle and serial outputs of the UART transmitter.
interface uart_tx_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic [PRESCALE_W-1:0] prescale;
  logic                  tx_out;
  logic                  busy;

  modport master (
    output p_data, data_valid, par_en, par_typ, prescale,
    input  tx_out, busy
  );

  modport slave (
    input  p_data, data_valid, par_en, par_typ, prescale,
    output tx_out, busy
  );

endinterface

// File: rtl/tx_bit_timer.sv
// Per-bit tick counter: flags the last tick of each serial bit and counts bits
// within the current FSM state; start restarts both from zero.
module tx_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  run,
  input  logic [PRESCALE_W-1:0] limit,
  output logic                  bit_done,
  output logic [IDX_W-1:0]      bit_index
);

  logic [PRESCALE_W-1:0] cnt;

  // bit_done is registered one tick early so it is high exactly while cnt == limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      bit_done  <= 1'b0;
      bit_index <= '0;
    end else if (start) begin
      cnt       <= '0;
      bit_done  <= (limit == '0);
      bit_index <= '0;
    end else if (run) begin
      if (bit_done) begin
        cnt       <= '0;
        bit_done  <= (limit == '0);
        bit_index <= bit_index + IDX_W'(1);
      end else begin
        cnt       <= cnt + PRESCALE_W'(1);
        bit_done  <= (PRESCALE_W'(cnt + PRESCALE_W'(1)) == limit);
      end
    end else begin
      cnt       <= '0;
      bit_done  <= 1'b0;
      bit_index <= '0;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first payload, optional parity, stop bit,
// with back-to-back acceptance on the last tick of the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic     clk_based_on_prescale,
  input  logic     asy_reset,
  uart_tx_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DATA_WIDTH + 1);

  uart_state_e           state;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_bit;
  logic                  par_en_q;
  logic [PRESCALE_W-1:0] ps_q;
  logic                  tx_line;
  logic                  busy_q;

  logic                  bit_done;
  logic [IDX_W-1:0]      bit_index;

  logic                  accept_c;
  logic                  last_bit_c;
  logic                  restart_c;
  logic [PRESCALE_W-1:0] limit_c;

  assign accept_c   = bus.data_valid && ((state == IDLE) || ((state == STOP) && bit_done));
  assign last_bit_c = (bit_index == IDX_W'(DATA_WIDTH - 1));
  // Timer restarts on every state change so bit_index counts bits of the current state only.
  assign restart_c  = accept_c || (bit_done && ((state != DATA) || last_bit_c));
  assign limit_c    = accept_c ? tick_limit(bus.prescale) : tick_limit(ps_q);

  tx_bit_timer #(
    .IDX_W (IDX_W)
  ) u_timer (
    .clk       (clk_based_on_prescale),
    .rst       (asy_reset),
    .start     (restart_c),
    .run       (state != IDLE),
    .limit     (limit_c),
    .bit_done  (bit_done),
    .bit_index (bit_index)
  );

  always_ff @(posedge clk_based_on_prescale or posedge asy_reset) begin
    if (asy_reset) begin
      state    <= IDLE;
      shreg    <= '0;
      par_bit  <= 1'b0;
      par_en_q <= 1'b0;
      ps_q     <= '0;
      tx_line  <= 1'b1;
      busy_q   <= 1'b0;
    end else if (accept_c) begin
      state    <= START;
      shreg    <= bus.p_data;
      par_bit  <= (^bus.p_data) ^ (bus.par_typ == PAR_ODD);
      par_en_q <= bus.par_en;
      ps_q     <= bus.prescale;
      tx_line  <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx_line <= 1'b1;
          busy_q  <= 1'b0;
        end
        START: begin
          if (bit_done) begin
            state   <= DATA;
            tx_line <= shreg[0];
            shreg   <= shreg >> 1;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (last_bit_c) begin
              state   <= par_en_q ? PARITY : STOP;
              tx_line <= par_en_q ? par_bit : 1'b1;
            end else begin
              tx_line <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            state   <= STOP;
            tx_line <= 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            state   <= IDLE;
            tx_line <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          tx_line <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_out = tx_line;
  assign bus.busy   = busy_q;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the number of payload bits per frame.
REQ-002 SHALL have port clk_based_on_prescale, input, 1, the single clock (one tick per oversample edge).
REQ-003 SHALL have port asy_reset, input, 1, an asynchronous, active-high reset.
REQ-004 SHALL have port p_data, input, DATA_WIDTH, the parallel payload.
REQ-005 SHALL have port data_valid, input, 1, the request to send p_data.
REQ-006 SHALL have port par_en, input, 1, the parity-bit enable.
REQ-007 SHALL have port par_typ, input, 1, the parity type: 0 = even, 1 = odd.
REQ-008 SHALL have port prescale, input, 6, the clock ticks per serial bit.
REQ-009 SHALL have port tx_out, output, 1, the serial line, which idles at 1.
REQ-010 SHALL have port busy, output, 1, which is high while a frame is in flight.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-012 SHALL accept a frame on the clock edge where data_valid=1 and the state is IDLE, or the state is STOP on its last tick.
REQ-013 SHALL, at acceptance, latch p_data, par_en, par_typ and prescale; input changes during the frame have no effect.
REQ-014 SHALL drive tx_out and busy as registered outputs: at the acceptance edge, tx_out becomes 0 and busy becomes 1 (latency of one edge).
REQ-015 SHALL hold each serial bit (start, each data bit, parity, stop) for exactly the latched prescale number of ticks.
REQ-016 SHALL treat a latched prescale of 0 as 1.
REQ-017 SHALL send frame order: start 0, then data LSB first, then parity (only if par_en), then stop 1.
REQ-018 SHALL use parity = XOR of the latched data, inverted when par_typ=1.
REQ-019 SHALL transition START->DATA after prescale ticks; DATA->PARITY (par_en=1) or DATA->STOP (par_en=0) after DATA_WIDTH bits; PARITY->STOP; STOP->IDLE, or STOP->START on back-to-back acceptance.
REQ-020 SHALL give a frame duration of (DATA_WIDTH+2+par_en)*prescale ticks, with busy high for exactly that span when no back-to-back frame follows.
REQ-021 SHALL ignore data_valid at all other times, with no queuing and no error flag.
REQ-022 SHALL, on back-to-back acceptance, keep busy at 1 and follow the stop bit directly with the new start bit, with no idle tick.
REQ-023 SHALL keep the tick counter at 6 bits and the bit index at ceil(log2(DATA_WIDTH+1)) bits; both clear at every bit or state boundary, with no wrap beyond prescale-1.

Reset
REQ-024 SHALL, while asy_reset=1, force tx_out=1, busy=0, state IDLE, and all counters and latches to 0, asynchronously.
REQ-025 SHALL, on reset assertion mid-frame, abort the frame immediately with no stop bit completion; the line returns to 1.
REQ-026 SHALL act on data_valid no earlier than the first clock edge after asy_reset deasserts.

Structure
REQ-027 SHALL place the state encoding, parity-type constants (PAR_EVEN=0, PAR_ODD=1) and the default DATA_WIDTH in shared package uart_pkg, which the RX blocks also use.
REQ-028 SHALL contain one sub-module, tx_bit_timer, which counts ticks to prescale-1, pulses bit_done and advances bit_index, restarting on a start pulse from the FSM.
REQ-029 SHALL keep parity calculation and the serializer shift register in uart_tx.

Verification
REQ-030 SHALL verify: p_data=0xA5, par_en=0, prescale=8 -> tx_out = 0,1,0,1,0,0,1,0,1,1, each held 8 ticks; busy high for 80 ticks.
REQ-031 SHALL verify: p_data=0xA5, par_en=1, par_typ=0, prescale=16 -> parity bit 0; frame 176 ticks. With par_typ=1 -> parity bit 1.
REQ-032 SHALL verify: data_valid held high with 0x55 then 0x0F, prescale=8 -> second start bit begins on the tick after the first stop bit's 8th tick; busy never drops between frames.
REQ-033 SHALL verify: data_valid pulsed with 0xFF during DATA of frame 0x00 -> frame 0x00 completes unaltered; 0xFF is never sent.
REQ-034 SHALL verify: asy_reset asserted during data bit 3 -> tx_out=1 and busy=0 immediately with no clock edge required; a new frame sends correctly after release.
REQ-035 SHALL verify: prescale=0, p_data=0x01, par_en=0 -> each bit lasts 1 tick; frame 10 ticks.
